// File: rtl/merge_runs.sv
// Two-way merge of sorted runs held in first-word-fall-through FIFOs.
// Emits one element per cycle into a registered, backpressured output slot.
module merge_runs #(
    parameter int DATA_W  = 8,
    parameter int MAX_RUN = 256,
    localparam int CNT_W  = $clog2(MAX_RUN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  run_len,
    input  logic              descend,
    input  logic [DATA_W-1:0] l_data,
    input  logic [DATA_W-1:0] r_data,
    input  logic              l_empty,
    input  logic              r_empty,
    output logic              l_rd,
    output logic              r_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        MERGE,
        DRAIN_L,
        DRAIN_R,
        FLUSH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] i;
    logic [CNT_W-1:0] j;
    logic             desc;

    logic             slot_free;
    logic             both_ready;
    logic             take_left;
    logic             pop_l;
    logic             pop_r;
    logic [CNT_W-1:0] i_nxt;
    logic [CNT_W-1:0] j_nxt;
    logic [CNT_W:0]   sum_nxt;
    logic [CNT_W:0]   total;
    logic [CNT_W-1:0] len_sat;

    assign slot_free  = !out_valid || out_ready;
    assign both_ready = !l_empty && !r_empty;

    // Ties resolve to the left run so equal keys keep their order.
    assign take_left = desc ? (l_data >= r_data) : (l_data <= r_data);

    always_comb begin
        pop_l = 1'b0;
        pop_r = 1'b0;
        case (state)
            MERGE: begin
                if (both_ready && slot_free) begin
                    pop_l = take_left;
                    pop_r = !take_left;
                end
            end
            DRAIN_L: pop_l = !l_empty && slot_free;
            DRAIN_R: pop_r = !r_empty && slot_free;
            default: begin
                pop_l = 1'b0;
                pop_r = 1'b0;
            end
        endcase
    end

    assign l_rd = pop_l && !rst;
    assign r_rd = pop_r && !rst;
    assign busy = (state != IDLE);

    assign i_nxt   = i + CNT_W'(pop_l);
    assign j_nxt   = j + CNT_W'(pop_r);
    assign sum_nxt = {1'b0, i_nxt} + {1'b0, j_nxt};
    assign total   = {len, 1'b0};

    assign len_sat = (run_len > CNT_W'(MAX_RUN)) ? CNT_W'(MAX_RUN) : run_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            i         <= '0;
            j         <= '0;
            desc      <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            i    <= i_nxt;
            j    <= j_nxt;

            if (pop_l || pop_r) begin
                out_data  <= pop_l ? l_data : r_data;
                out_src   <= pop_r;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len   <= len_sat;
                        desc  <= descend;
                        i     <= '0;
                        j     <= '0;
                        state <= (len_sat == '0) ? FLUSH : MERGE;
                    end
                end
                MERGE, DRAIN_L, DRAIN_R: begin
                    // Completion wins over the drain hand-off.
                    if (sum_nxt == total) begin
                        state <= FLUSH;
                    end else if (i_nxt == len) begin
                        state <= DRAIN_R;
                    end else if (j_nxt == len) begin
                        state <= DRAIN_L;
                    end
                end
                FLUSH: begin
                    if (slot_free) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/merge_runs.md
MERGE_RUNS -- requirements
Module: merge_runs

Parameters
REQ-001 DATA_W, default 8, width of each sorted element.
REQ-002 MAX_RUN, default 256, maximum elements per input run; CNT_W = $clog2(MAX_RUN+1).

Interface
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin a merge; sampled only in IDLE.
REQ-006 run_len  input  CNT_W  elements per run; latched at start.
REQ-007 descend  input  1  0 = ascending merge, 1 = descending; latched at start.
REQ-008 l_data / r_data  input  DATA_W  head word of left/right FIFO (first-word-fall-through).
REQ-009 l_empty / r_empty  input  1  left/right FIFO empty.
REQ-010 l_rd / r_rd  output  1  combinational pop strobe for left/right FIFO.
REQ-011 out_data  output  DATA_W  merged element (registered).
REQ-012 out_src  output  1  source of out_data: 0 = left, 1 = right.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  downstream accepts out_data when out_valid is high.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when the merge completes.

Function
REQ-017 States: IDLE, MERGE, DRAIN_L, DRAIN_R, FLUSH; encoding is free.
REQ-018 Counters i (left taken) and j (right taken) are CNT_W wide; both clear on start.
REQ-019 run_len greater than MAX_RUN is saturated to MAX_RUN at latch time.
REQ-020 IDLE with start=1 and latched run_len=0: go to FLUSH with no pops; done pulses the next cycle.
REQ-021 IDLE with start=1 and run_len>0: go to MERGE; no pop is issued in the start cycle.
REQ-022 Slot free = !out_valid || out_ready; at most one pop (l_rd or r_rd) per cycle, only when the slot is free.
REQ-023 MERGE selects left when (descend ? l_data >= r_data : l_data <= r_data); ties always take left (stable).
REQ-024 MERGE pops only when both FIFOs are non-empty; otherwise it stalls without popping.
REQ-025 Pop cycle: load out_data with the selected head, set out_src, set out_valid=1, increment i or j.
REQ-026 When i reaches run_len, go to DRAIN_R; when j reaches run_len, go to DRAIN_L.
REQ-027 DRAIN_L/DRAIN_R pop only the remaining side, with no comparison, gated by that side's empty flag and the slot-free rule.
REQ-028 When i+j = 2*run_len (CNT_W+1-bit sum), go to FLUSH; no further pops are issued.
REQ-029 FLUSH waits for the final out_valid&&out_ready, then pulses done and returns to IDLE.
REQ-030 Pop-to-out_valid latency is exactly 1 cycle; throughput is 1 element/cycle with out_ready held high.
REQ-031 out_valid stays high and out_data/out_src stay stable until accepted.
REQ-032 With no new pop, out_valid clears on acceptance.
REQ-033 start while busy is ignored.
REQ-034 l_rd and r_rd are never asserted in IDLE or FLUSH, during rst, or when the popped FIFO is empty.

Reset
REQ-035 rst=1 immediately forces state IDLE and clears i, j, out_data, out_src, out_valid, busy and done, independent of clk.
REQ-036 rst asserted mid-merge aborts the merge; no pop or done occurs.
REQ-037 After rst deassertion, the block requires a new start; FIFO contents are not the block's concern.

Verification
REQ-038 Ascending merge: run_len=4, L={1,3,5,7}, R={2,4,6,8}, out_ready=1 -> out 1..8 on 8 consecutive cycles, out_src=0,1,0,1,0,1,0,1, done 1 cycle after last accept.
REQ-039 Ties and drain: run_len=3, L={2,2,9}, R={2,3,4} -> out 2(L),2(L),2(R),3(R),4(R),9(L); DRAIN_L entered after the third R pop.
REQ-040 Descending merge: descend=1, run_len=2, L={9,1}, R={5,4} -> out 9,5,4,1.
REQ-041 Backpressure and empty stall: out_ready toggles 1/0 and l_empty is pulsed high for 3 cycles mid-run -> no lost or duplicated element, out_data stable while out_valid&&!out_ready, no pop while l_empty=1 in MERGE.
REQ-042 Zero length and saturation: run_len=0 -> no pops, done 2 cycles after start; run_len=MAX_RUN+5 -> exactly 2*MAX_RUN outputs.
REQ-043 Reset mid-merge: rst asserted asynchronously after the 3rd output -> out_valid=0 and busy=0 before the next clk edge, no done; a following start merges correctly from i=j=0.
